// File: rtl/ram_burst_reader.sv
// ram_burst_reader
// ----------------
// Burst read engine for the read port of a two-port RAM. A request supplies a
// start address and a word count. The engine walks the RAM read address
// upward, wrapping modulo the RAM depth, and streams each word through a
// one-entry registered valid/ready output stage that supports backpressure.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       burst request, sampled only while idle
//   start_addr  first RAM address of the burst
//   burst_len   word count 1..2**ADDR_WIDTH; 0 means the request is ignored
//   busy        high while a burst is in progress
//   done        one-cycle pulse in the cycle after the final beat handshake
//   r_addr      RAM read address
//   r_data      RAM read data, combinational from r_addr
//   out_data    streamed word (registered)
//   out_valid   out_data holds a valid beat
//   out_ready   downstream accepts the beat
//   out_last    final beat of the burst (only when RAM_RD_LAST_EN is defined)
//
// Build option
//   RAM_RD_LAST_EN  adds the out_last port and its register.

module ram_burst_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef RAM_RD_LAST_EN
  ,
  output logic                  out_last
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  done_q;

  // Control strobes produced by the next-state logic.
  logic load;     // accept a new burst request
  logic capture;  // move r_data into the output register
  logic finish;   // final beat handed off

  wire last_word = (remain_q == (ADDR_WIDTH + 1)'(1));

  // ---------------------------------------------------------------------------
  // Next-state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && (burst_len != '0)) begin
          load    = 1'b1;
          state_d = S_READ;
        end
      end

      S_READ: begin
        // The output register is free when empty or being drained this cycle.
        if (!out_valid_q || out_ready) begin
          capture = 1'b1;
          if (last_word) state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (out_valid_q && out_ready) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the reset is synchronous (inside the clocked branch), and it clears
  // out_data too so every output reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remain_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= finish;

      if (load) begin
        addr_q   <= start_addr;
        remain_q <= burst_len;
      end

      if (capture) begin
        out_data_q  <= r_data;
        out_valid_q <= 1'b1;
        addr_q      <= addr_q + 1'b1;  // wraps modulo the RAM depth
        remain_q    <= remain_q - 1'b1;
      end

      if (finish) out_valid_q <= 1'b0;
    end
  end

`ifdef RAM_RD_LAST_EN
  logic out_last_q;

  // Travels with out_data: set by the capture of the final word, cleared
  // together with out_valid once that beat is handed off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_last_q <= 1'b0;
    end else begin
      if (capture) out_last_q <= last_word;
      if (finish)  out_last_q <= 1'b0;
    end
  end

  assign out_last = out_last_q;
`endif

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign r_addr    = addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader. A behavioural RAM array feeds
// r_data; each burst's expected word list is built from that array with
// modular address arithmetic and compared beat by beat at the output.

module tb_ram_burst_reader;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   burst_len;
  logic          busy;
  logic          done;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef RAM_RD_LAST_EN
  logic          out_last;
`endif

  logic [DW-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign r_data = mem[r_addr];

  ram_burst_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RAM_RD_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_raddr"}, r_addr, 0);
    check({tag, "_data"},  out_data, 0);
    check({tag, "_valid"}, out_valid, 0);
`ifdef RAM_RD_LAST_EN
    check({tag, "_last"},  out_last, 0);
`endif
  endtask

  // One burst from request to done pulse.
  //   stall_pct : chance (percent) of out_ready low on any cycle
  //   stall_idx : beat index held with out_ready low for 3 cycles (-1: none)
  //   mid_start : throw random start requests while the burst runs
  task automatic do_burst(input logic [AW-1:0] sa, input logic [AW:0] len,
                          input int stall_pct, input int stall_idx, input bit mid_start);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held_data;
    bit            held;
    int            idx;
    int            cycles;
    int            stall_cnt;

    for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[(int'(sa) + i) % DEPTH]);

    tick();
    start      = 1'b1;
    start_addr = sa;
    burst_len  = len;
    out_ready  = 1'b0;
    tick();
    start = 1'b0;

    if (len == 0) begin
      for (int c = 0; c < 3; c++) begin
        #1;
        check("len0_busy", busy, 0);
        check("len0_done", done, 0);
        check("len0_valid", out_valid, 0);
        tick();
      end
      return;
    end

    #1;
    check("lat_busy", busy, 1);
    check("lat_raddr", r_addr, sa);
    check("lat_valid", out_valid, 0);

    idx = 0; cycles = 0; held = 1'b0; held_data = '0; stall_cnt = 0;
    while (idx < int'(len) && cycles < 300) begin
      if (cycles > 0) begin
        if (out_valid && idx == stall_idx && stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = ($urandom_range(0, 99) >= stall_pct);
        end
        if (mid_start) begin
          start      = $urandom_range(0, 1) == 1;
          start_addr = AW'($urandom);
          burst_len  = (AW + 1)'($urandom_range(1, DEPTH));
        end
        #1;
      end
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
      end
      check("busy", busy, 1);
      check("done_early", done, 0);
      held = 1'b0;
      if (out_valid) begin
        if (idx < int'(len)) begin
          check($sformatf("beat%0d_data", idx), out_data, exp_q[idx]);
`ifdef RAM_RD_LAST_EN
          check($sformatf("beat%0d_last", idx), out_last, idx == int'(len) - 1);
`endif
        end
        if (out_ready) begin
          idx++;
        end else begin
          held      = 1'b1;
          held_data = out_data;
        end
      end
      tick();
      cycles++;
    end
    if (idx < int'(len)) check("timeout_beats", idx, len);
    if (stall_pct == 0 && stall_idx < 0) check("throughput", cycles, int'(len) + 1);

    // Cycle after the final handshake.
    start     = 1'b0;
    out_ready = ($urandom_range(0, 1) == 1);
    #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", out_valid, 0);
`ifdef RAM_RD_LAST_EN
    check("done_last", out_last, 0);
`endif
    tick();
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic reset_mid_burst();
    int beats;
    int cycles;
    tick();
    start      = 1'b1;
    start_addr = 3'd3;
    burst_len  = 4'd6;
    out_ready  = 1'b1;
    tick();
    start  = 1'b0;
    beats  = 0;
    cycles = 0;
    while (beats < 2 && cycles < 50) begin
      #1;
      if (out_valid && out_ready) beats++;
      tick();
      cycles++;
    end
    check("rst_two_beats", beats, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("rst_mid");
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_no_done", done, 0);
      check("rst_idle", busy, 0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    burst_len  = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'h10 + i);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    do_burst(3'd2, 4'd4, 0, -1, 1'b0);   // basic
    do_burst(3'd6, 4'd4, 0, -1, 1'b0);   // wrap-around
    do_burst(3'd0, 4'd5, 0, 1, 1'b0);    // 0x11 stalled 3 cycles
    do_burst(3'd3, 4'd0, 0, -1, 1'b0);   // zero length ignored
    do_burst(3'd5, 4'd8, 0, -1, 1'b0);   // full depth
    do_burst(3'd0, 4'd7, 30, -1, 1'b1);  // start requests mid-burst
    reset_mid_burst();
    do_burst(3'd1, 4'd2, 0, -1, 1'b0);   // clean burst after reset

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      do_burst(AW'($urandom), (AW + 1)'($urandom_range(0, DEPTH)),
               $urandom_range(0, 60), -1, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
